mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port 32-bit x 64K memory file between two requesters: port A (core data path) and port B (DMA/loader engine).
- Round-robin arbitration, one transaction in flight at a time.
- Drives the memory's address, write-data and write-enable pins.
- Registers the memory's asynchronous read data back to the winning requester.

Parameters:
- DATA_W, 32, data width of the memory and of both requester ports
- ADDR_W, 16, address width (64K words)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- a_req  in  1  port A request valid; held until a_ready=1
- a_we  in  1  port A: 1=write, 0=read
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_ready  out  1  port A request accepted this cycle
- a_done  out  1  one-cycle pulse: port A transaction complete
- a_rdata  out  DATA_W  port A read data, valid when a_done=1 and the transaction was a read
- b_req, b_we, b_addr, b_wdata, b_ready, b_done, b_rdata  same as the A signals, for port B
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory WriteData
- mem_we  out  1  to memory WriteEnable
- mem_rdata  in  DATA_W  from memory ReadData (combinational read)

Behaviour:
- FSM states: IDLE, ACCESS.
  - IDLE: if any req, accept the winner (x_ready=1 combinationally that cycle), latch we/addr/wdata/requester id, and go to ACCESS.
  - ACCESS: drive mem_addr/mem_wdata/mem_we from the latched values; always return to IDLE next cycle.
- Arbitration (IDLE only):
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last wins.
  - last_grant resets to B, so A wins the first contention.
  - last_grant updates only on acceptance.
- Ready: at most one of a_ready/b_ready is high in any cycle; both are 0 in ACCESS.
- Latency: request accepted at edge N; ACCESS is cycle N+1; x_done pulses in cycle N+2 (one cycle).
  - Read: mem_rdata is sampled at the end of ACCESS into x_rdata, which holds until that port's next read completes.
  - Write: memory commits at the end of ACCESS; x_rdata is unchanged.
- Throughput: one transaction per 2 cycles. The done cycle is IDLE, so a new acceptance may coincide with x_done.
- mem_we is high only in ACCESS for writes; 0 in IDLE. mem_addr/mem_wdata hold their last values in IDLE (no glitch-driven writes).
- Reset values: state=IDLE, last_grant=B, all ready/done=0, mem_we=0, mem_addr=0, mem_wdata=0, a_rdata=b_rdata=0.
- Reset asserted during ACCESS:
  - mem_we is already registered high that cycle, so the write commits; the memory itself is not reset.
  - No done pulse is issued.
  - The FSM returns to IDLE.
- Requester dropping x_req before ready: legal; nothing is latched.
- Address wrap: none; ADDR_W covers the full memory.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs a_grant_cnt and b_grant_cnt [15:0]: counts of accepted transactions per port, saturating at 16'hFFFF, cleared by reset.
  - Adds output contention_cnt [15:0]: cycles in IDLE with both req high, saturating, cleared by reset.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_ACCESS=1'b1
  - requester ids REQ_A=1'b0, REQ_B=1'b1
  - CNT_W=16 for the perf counters
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last[0].
  - Outputs: gnt[1:0] (one-hot or zero), gnt_id.
  - Instantiated once.

Test Plan:
- After reset release, A writes 0xDEADBEEF to addr 0x0010, then A reads 0x0010 -> a_ready at the request cycles, a_done at N+2, a_rdata=0xDEADBEEF, b_done never pulses.
- A and B both request continuously from the same cycle (A reads 0x0001, B reads 0x0002; memory preloaded with 0x11/0x22) -> grants alternate A,B,A,B; each a_done carries 0x11 and each b_done carries 0x22; neither ready is high during ACCESS.
- B writes 0x5 to 0x00FF while A is held low, then back-to-back B reads of 0x00FF -> b_ready on every IDLE cycle, one done every 2 cycles, b_rdata=0x5.
- Reset pulled low in the ACCESS cycle of an A write of 0xCAFE to 0x0100 -> no a_done; state IDLE afterwards; a subsequent read of 0x0100 returns 0xCAFE; all outputs are at reset values the cycle after the reset edge.
- A requests then drops a_req before acceptance while B holds a_ready low (B mid-ACCESS) -> no A transaction; the memory location is unchanged.
- With MEM_ARB_PERF_CNT_EN defined: 3 A and 2 B accepts, with 2 contention cycles -> a_grant_cnt=3, b_grant_cnt=2, contention_cnt=2; forcing 70000 A accepts -> a_grant_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for mem_port_arbiter: FSM encoding, requester ids and perf-counter width.
// sat_inc is only used when MEM_ARB_PERF_CNT_EN is defined.
package mem_arb_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam logic [0:0] REQ_A = 1'b0;
   localparam logic [0:0] REQ_B = 1'b1;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, on contention
// the requester that was not granted last wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      gnt_id = REQ_A;
      gnt    = 2'b00;
      case (req)
         2'b01:   gnt_id = REQ_A;
         2'b10:   gnt_id = REQ_B;
         2'b11:   gnt_id = (last == REQ_B) ? REQ_A : REQ_B;
         default: gnt_id = REQ_A;
      endcase
      if (req != 2'b00) begin
         gnt = (gnt_id == REQ_B) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port 32-bit x 64K memory between port A and port B,
// one transaction in flight. Define MEM_ARB_PERF_CNT_EN to add grant/contention counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ready,
   output logic              a_done,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  a_grant_cnt,
   output logic [CNT_W-1:0]  b_grant_cnt,
   output logic [CNT_W-1:0]  contention_cnt
`endif
);

   logic [0:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              a_done_q, a_done_d;
   logic              b_done_q, b_done_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic              accept;

   rr_arb2 u_rr_arb2 (
      .req    ({b_req, a_req}),
      .last   (last_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Ready is masked while reset is low: nothing can be accepted on a reset edge.
   assign accept  = reset && (state_q == ST_IDLE) && (gnt != 2'b00);
   assign a_ready = accept && gnt[0];
   assign b_ready = accept && gnt[1];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      a_done_d    = 1'b0;
      b_done_d    = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d     = ST_ACCESS;
               last_d      = gnt_id;
               id_d        = gnt_id;
               mem_we_d    = (gnt_id == REQ_B) ? b_we    : a_we;
               mem_addr_d  = (gnt_id == REQ_B) ? b_addr  : a_addr;
               mem_wdata_d = (gnt_id == REQ_B) ? b_wdata : a_wdata;
            end
         end
         ST_ACCESS: begin
            state_d = ST_IDLE;
            if (id_q == REQ_B) begin
               b_done_d = 1'b1;
               if (!mem_we_q) b_rdata_d = mem_rdata;
            end else begin
               a_done_d = 1'b1;
               if (!mem_we_q) a_rdata_d = mem_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A reset edge ending ACCESS still sees mem_we high, so the memory commits that write.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         state_q     <= ST_IDLE;
         last_q      <= REQ_B;
         id_q        <= REQ_A;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         a_done_q    <= 1'b0;
         b_done_q    <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         a_done_q    <= a_done_d;
         b_done_q    <= b_done_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign a_done    = a_done_q;
   assign b_done    = b_done_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [CNT_W-1:0] a_cnt_q, b_cnt_q, cont_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         cont_q  <= '0;
      end else begin
         if (a_ready) a_cnt_q <= sat_inc(a_cnt_q);
         if (b_ready) b_cnt_q <= sat_inc(b_cnt_q);
         if ((state_q == ST_IDLE) && a_req && b_req) cont_q <= sat_inc(cont_q);
      end
   end

   assign a_grant_cnt    = a_cnt_q;
   assign b_grant_cnt    = b_cnt_q;
   assign contention_cnt = cont_q;
`endif

endmodule
